// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//
// Write-side controller for the fetch-stage branch target buffer. Update
// requests from taken conditional branches (resolved in MEM) and from jumps
// (resolved in EX) are queued in a small FIFO and drained onto the BTB's single
// write port at one write per cycle. On flush_req the controller discards the
// queue and walks every BTB entry, writing it invalid.
//
// Build option:
//   BTB_UPD_COALESCE_EN  when defined, an accepted request whose PC matches an
//                        entry still waiting in the queue updates that entry's
//                        target in place instead of pushing a duplicate.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   br_req      MEM-stage taken-branch update request (br_pc, br_target)
//   jmp_req     EX-stage jump update request (jmp_pc, jmp_target)
//   flush_req   invalidate the whole BTB
//   stall       requests are not accepted this cycle; requesters hold them
//   busy        invalidate walk in progress
//   btb_we      BTB write strobe
//   btb_idx     entry written
//   btb_pc      tag value written
//   btb_target  target written
//   btb_vld     valid bit written (0 during the walk)
// All outputs are registered.
// -----------------------------------------------------------------------------
module btb_update_ctrl #(
  parameter int BTB_SIZE   = 16,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_req,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_target,
  input  logic             jmp_req,
  input  logic [31:0]      jmp_pc,
  input  logic [31:0]      jmp_target,
  input  logic             flush_req,
  output logic             stall,
  output logic             busy,
  output logic             btb_we,
  output logic [IDX_W-1:0] btb_idx,
  output logic [31:0]      btb_pc,
  output logic [31:0]      btb_target,
  output logic             btb_vld
);

  localparam int SLOT_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = SLOT_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BTB_SIZE - 1);
  localparam logic [PTR_W-1:0] DEPTH_M1 = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t state, state_n;

  // cnt is the table index being invalidated during the current FLUSH cycle.
  logic [IDX_W-1:0] cnt, cnt_n;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0] count, count_n, wp;
  logic [SLOT_W-1:0] head;
  logic             fifo_empty, full_n;

  logic [31:0] q_pc    [FIFO_DEPTH];
  logic [31:0] q_tgt   [FIFO_DEPTH];
  logic [31:0] q_pc_n  [FIFO_DEPTH];
  logic [31:0] q_tgt_n [FIFO_DEPTH];

  logic             br_acc, jmp_acc;
  logic             br_push, jmp_push;

  logic             stall_n, busy_n, we_n, vld_n;
  logic [IDX_W-1:0] idx_n;
  logic [31:0]      pc_n, tgt_n;

`ifdef BTB_UPD_COALESCE_EN
  logic [SLOT_W-1:0] slot_off;
`endif

  assign head       = rd_ptr[SLOT_W-1:0];
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr[PTR_W-1] == rd_ptr[PTR_W-1]) &&
                      (wr_ptr[SLOT_W-1:0] == rd_ptr[SLOT_W-1:0]);

  // ---------------------------------------------------------------------------
  // Next-state, queue update and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_n  = state;
    cnt_n    = cnt;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    q_pc_n   = q_pc;
    q_tgt_n  = q_tgt;
    we_n     = 1'b0;
    idx_n    = '0;
    pc_n     = '0;
    tgt_n    = '0;
    vld_n    = 1'b0;
    wp       = wr_ptr;
    br_acc   = br_req & ~stall;
    jmp_acc  = jmp_req & ~stall;
    br_push  = br_acc;
    jmp_push = jmp_acc;
`ifdef BTB_UPD_COALESCE_EN
    slot_off = '0;
`endif

    unique case (state)
      IDLE: begin
        if (flush_req) begin
          // Flush wins over same-cycle requests and discards the queue.
          state_n  = FLUSH;
          cnt_n    = '0;
          wr_ptr_n = '0;
          rd_ptr_n = '0;
          we_n     = 1'b1;
        end else begin
`ifdef BTB_UPD_COALESCE_EN
          // Same PC from both sources collapses to one entry with the br target.
          if (br_acc && jmp_acc && (br_pc == jmp_pc)) begin
            jmp_push = 1'b0;
          end
          for (int i = 0; i < FIFO_DEPTH; i++) begin
            slot_off = SLOT_W'(i) - head;
            // The head leaves this cycle whenever the queue is non-empty, so
            // only entries queued behind it may absorb a new request.
            if ((slot_off != '0) && ({1'b0, slot_off} < count)) begin
              if (br_push && (q_pc[i] == br_pc)) begin
                q_tgt_n[i] = br_target;
                br_push    = 1'b0;
              end
              if (jmp_push && (q_pc[i] == jmp_pc)) begin
                q_tgt_n[i] = jmp_target;
                jmp_push   = 1'b0;
              end
            end
          end
`endif
          // Oldest first: queued head, else bypass a new request straight to
          // the write port so an empty queue costs one cycle of latency.
          if (!fifo_empty) begin
            we_n     = 1'b1;
            vld_n    = 1'b1;
            idx_n    = q_pc[head][IDX_W+1:2];
            pc_n     = q_pc[head];
            tgt_n    = q_tgt[head];
            rd_ptr_n = rd_ptr + PTR_W'(1);
          end else if (br_push) begin
            we_n    = 1'b1;
            vld_n   = 1'b1;
            idx_n   = br_pc[IDX_W+1:2];
            pc_n    = br_pc;
            tgt_n   = br_target;
            br_push = 1'b0;
          end else if (jmp_push) begin
            we_n     = 1'b1;
            vld_n    = 1'b1;
            idx_n    = jmp_pc[IDX_W+1:2];
            pc_n     = jmp_pc;
            tgt_n    = jmp_target;
            jmp_push = 1'b0;
          end

          // br is older in program order, so it takes the first free slot.
          if (br_push) begin
            q_pc_n[wp[SLOT_W-1:0]]  = br_pc;
            q_tgt_n[wp[SLOT_W-1:0]] = br_target;
            wp                      = wp + PTR_W'(1);
          end
          if (jmp_push) begin
            q_pc_n[wp[SLOT_W-1:0]]  = jmp_pc;
            q_tgt_n[wp[SLOT_W-1:0]] = jmp_target;
            wp                      = wp + PTR_W'(1);
          end
          wr_ptr_n = wp;
        end
      end

      FLUSH: begin
        // flush_req is ignored here; the walk always runs to the last entry.
        if (cnt == LAST_IDX) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + IDX_W'(1);
          we_n  = 1'b1;
          idx_n = cnt_n;
        end
      end

      default: state_n = IDLE;
    endcase

    // stall is registered from post-edge occupancy so it never depends
    // combinationally on the request inputs.
    count_n = wr_ptr_n - rd_ptr_n;
    full_n  = (wr_ptr_n[PTR_W-1] != rd_ptr_n[PTR_W-1]) &&
              (wr_ptr_n[SLOT_W-1:0] == rd_ptr_n[SLOT_W-1:0]);
    busy_n  = (state_n == FLUSH);
    stall_n = busy_n | full_n | (count_n >= DEPTH_M1);
  end

  // ---------------------------------------------------------------------------
  // Control state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      stall      <= 1'b0;
      busy       <= 1'b0;
      btb_we     <= 1'b0;
      btb_idx    <= '0;
      btb_pc     <= '0;
      btb_target <= '0;
      btb_vld    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      stall      <= stall_n;
      busy       <= busy_n;
      btb_we     <= we_n;
      btb_idx    <= idx_n;
      btb_pc     <= pc_n;
      btb_target <= tgt_n;
      btb_vld    <= vld_n;
    end
  end

  // NOTE: queue storage is deliberately not reset; the pointers alone define
  // which slots hold live entries, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      q_pc[i]  <= q_pc_n[i];
      q_tgt[i] <= q_tgt_n[i];
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btb_update_ctrl
//
// Self-checking bench for btb_update_ctrl. A behavioural model (a queue of
// pending updates plus a walk counter) predicts every BTB write; predictions
// go into a scoreboard queue and a negedge monitor compares them with the
// write port. stall and busy are compared against the model every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_btb_update_ctrl;

  localparam int BTB_SIZE   = 16;
  localparam int IDX_W      = 4;
  localparam int FIFO_DEPTH = 4;

`ifdef BTB_UPD_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             br_req, jmp_req, flush_req;
  logic [31:0]      br_pc, br_target, jmp_pc, jmp_target;
  logic             stall, busy, btb_we, btb_vld;
  logic [IDX_W-1:0] btb_idx;
  logic [31:0]      btb_pc, btb_target;

  always #5 clk = ~clk;

  btb_update_ctrl #(
    .BTB_SIZE  (BTB_SIZE),
    .IDX_W     (IDX_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .br_req    (br_req),
    .br_pc     (br_pc),
    .br_target (br_target),
    .jmp_req   (jmp_req),
    .jmp_pc    (jmp_pc),
    .jmp_target(jmp_target),
    .flush_req (flush_req),
    .stall     (stall),
    .busy      (busy),
    .btb_we    (btb_we),
    .btb_idx   (btb_idx),
    .btb_pc    (btb_pc),
    .btb_target(btb_target),
    .btb_vld   (btb_vld)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [31:0]      pc;
    logic [31:0]      tgt;
    logic             vld;
  } wr_t;

  ent_t m_q[$];     // model: pending updates, oldest first
  wr_t  exp_q[$];   // scoreboard: write expected in the cycle after an edge
  bit   m_busy;
  bit   m_stall;
  int   m_walk;

  int   n_checks;
  int   n_fail;
  bit   mon_en;
  int   pc40_writes;
  logic [31:0] pc40_last_tgt;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic wr_t mk_wr(input logic [31:0] pc, input logic [31:0] tgt, input logic vld,
                                input int idx);
    wr_t w;
    w.idx = IDX_W'(idx);
    w.pc  = pc;
    w.tgt = tgt;
    w.vld = vld;
    return w;
  endfunction

  // Append an update; with coalescing, an entry still waiting behind the
  // entry leaving this cycle takes the new target instead.
  task automatic model_add(input logic [31:0] pc, input logic [31:0] tgt, input int first);
    ent_t e;
    if (COALESCE) begin
      for (int i = first; i < m_q.size(); i++) begin
        if (m_q[i].pc == pc) begin
          e      = m_q[i];
          e.tgt  = tgt;
          m_q[i] = e;
          return;
        end
      end
    end
    e.pc  = pc;
    e.tgt = tgt;
    m_q.push_back(e);
  endtask

  // Behaviour of one clock edge given the inputs currently driven.
  task automatic model_step();
    ent_t e;
    bit   br_a, jmp_a;
    int   first;
    if (reset) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_walk  = 0;
      m_stall = 1'b0;
      return;
    end
    if (m_busy) begin
      if (m_walk == BTB_SIZE) begin
        m_busy = 1'b0;
      end else begin
        exp_q.push_back(mk_wr(32'h0, 32'h0, 1'b0, m_walk));
        m_walk++;
      end
    end else if (flush_req) begin
      m_q.delete();
      m_busy = 1'b1;
      exp_q.push_back(mk_wr(32'h0, 32'h0, 1'b0, 0));
      m_walk = 1;
    end else begin
      br_a  = br_req && !m_stall;
      jmp_a = jmp_req && !m_stall;
      first = (m_q.size() > 0) ? 1 : 0;
      if (br_a) model_add(br_pc, br_target, first);
      if (jmp_a && !(COALESCE && br_a && (br_pc == jmp_pc))) model_add(jmp_pc, jmp_target, first);
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        exp_q.push_back(mk_wr(e.pc, e.tgt, 1'b1, int'((e.pc >> 2) % BTB_SIZE)));
      end
    end
    m_stall = m_busy || ((FIFO_DEPTH - m_q.size()) < 2);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check stall/busy.
  task automatic step(input logic br_r, input logic [31:0] bp, input logic [31:0] bt,
                      input logic jr, input logic [31:0] jp, input logic [31:0] jt,
                      input logic fl, input logic rs);
    br_req     = br_r;
    br_pc      = bp;
    br_target  = bt;
    jmp_req    = jr;
    jmp_pc     = jp;
    jmp_target = jt;
    flush_req  = fl;
    reset      = rs;
    @(posedge clk);
    model_step();
    #1;
    check("stall", stall, m_stall);
    check("busy", busy, m_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Present a request and hold it until a cycle without stall accepts it.
  task automatic send(input logic br_r, input logic [31:0] bp, input logic [31:0] bt,
                      input logic jr, input logic [31:0] jp, input logic [31:0] jt);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      done = !m_stall;
      step(br_r, bp, bt, jr, jp, jt, 0, 0);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: request never accepted (t=%0t)", $time);
    end
  endtask

  // Scoreboard monitor: a write must appear exactly in the cycle predicted.
  always @(negedge clk) begin
    if (mon_en) begin
      wr_t e;
      check("btb_we", btb_we, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (btb_we) begin
          check("btb_write", {btb_idx, btb_pc, btb_target, btb_vld}, {e.idx, e.pc, e.tgt, e.vld});
        end
      end
      if (btb_we && btb_vld && (btb_pc == 32'h40)) begin
        pc40_writes++;
        pc40_last_tgt = btb_target;
      end
    end
  end

  initial begin
    int busy_cnt;
    logic        r_br, r_jmp, r_fl, r_rs;
    logic [31:0] r_bp, r_bt, r_jp, r_jt;

    n_checks    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    m_busy      = 1'b0;
    m_stall     = 1'b0;
    m_walk      = 0;
    pc40_writes = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("rst_we", btb_we, 1'b0);
    check("rst_idx", btb_idx, 4'h0);
    check("rst_pc", btb_pc, 32'h0);
    check("rst_target", btb_target, 32'h0);
    check("rst_vld", btb_vld, 1'b0);
    idle(2);

    // Single branch update, one-cycle latency, then idle bus
    send(1, 32'h40, 32'h100, 0, 0, 0);
    idle(3);

    // Same-cycle br and jmp: br first
    send(1, 32'h44, 32'h200, 1, 32'h88, 32'h300);
    idle(4);

    // Back-to-back dual requests: stall engages, order kept, pointers wrap
    for (int k = 0; k < 4; k++) begin
      send(1, 32'h100 + 32'(k * 16), 32'hA000 + 32'(k), 1, 32'h104 + 32'(k * 16), 32'hB000 + 32'(k));
    end
    idle(8);

    // Flush with three queued entries; flush_req held during part of the walk
    send(1, 32'h200, 32'h1, 1, 32'h204, 32'h2);
    send(1, 32'h208, 32'h3, 1, 32'h20C, 32'h4);
    send(1, 32'h210, 32'h5, 1, 32'h214, 32'h6);
    busy_cnt = 0;
    step(0, 0, 0, 0, 0, 0, 1, 0);
    if (busy) busy_cnt++;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 0);
      if (busy) busy_cnt++;
    end
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0);
      if (busy) busy_cnt++;
    end
    check("flush_busy_cycles", busy_cnt, 16);
    idle(2);

    // Reset in the middle of a walk, then normal service
    step(0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("midflush_rst_we", btb_we, 1'b0);
    check("midflush_rst_busy", busy, 1'b0);
    idle(3);
    send(1, 32'h7C, 32'hABC, 0, 0, 0);
    idle(3);

    // Duplicate PC while an older entry is ahead of it in the queue
    pc40_writes = 0;
    send(1, 32'h10, 32'h1, 1, 32'h14, 32'h2);
    send(1, 32'h18, 32'h3, 1, 32'h40, 32'h100);
    send(1, 32'h40, 32'h180, 0, 0, 0);
    idle(5);
    check("dup_pc40_writes", pc40_writes, COALESCE ? 1 : 2);
    check("dup_pc40_last_target", pc40_last_tgt, 32'h180);

    // Randomized traffic with a small PC pool, occasional flush and reset
    r_br = 0; r_jmp = 0; r_bp = 0; r_bt = 0; r_jp = 0; r_jt = 0;
    for (int c = 0; c < 600; c++) begin
      if (!m_stall) begin
        r_br  = ($urandom_range(0, 99) < 45);
        r_jmp = ($urandom_range(0, 99) < 45);
        r_bp  = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
        r_jp  = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
        r_bt  = $urandom;
        r_jt  = $urandom;
      end
      r_fl = ($urandom_range(0, 59) == 0);
      r_rs = ($urandom_range(0, 249) == 0);
      step(r_br, r_bp, r_bt, r_jmp, r_jp, r_jt, r_fl, r_rs);
    end
    idle(24);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Write-side controller for the fetch-stage branch target buffer. It queues BTB update requests from two resolution points: taken conditional branches resolved in MEM and jumps resolved in EX. It arbitrates them onto the BTB's single write port at one write per cycle. It also sequences a full-table invalidate walk on request (e.g. `fence.i`, context change).

## Interface
Parameters:
- `BTB_SIZE`, 16, number of BTB entries; power of two.
- `IDX_W`, 4, index width; equals log2(`BTB_SIZE`); index = `pc[IDX_W+1:2]`.
- `FIFO_DEPTH`, 4, update queue depth; power of two, minimum 2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `br_req`  in  1  MEM-stage taken-branch update request.
- `br_pc`  in  32  branch PC.
- `br_target`  in  32  resolved target.
- `jmp_req`  in  1  EX-stage jump update request.
- `jmp_pc`  in  32  jump PC.
- `jmp_target`  in  32  resolved target.
- `flush_req`  in  1  invalidate all BTB entries.
- `stall`  out  1  requests not accepted this cycle.
- `busy`  out  1  flush walk in progress.
- `btb_we`  out  1  BTB write strobe.
- `btb_idx`  out  `IDX_W`  entry written.
- `btb_pc`  out  32  tag value written.
- `btb_target`  out  32  target written.
- `btb_vld`  out  1  valid bit written; 0 during flush.

## Operation
Request acceptance:
- A request is accepted when its `*_req` is 1 and `stall` is 0. While `stall` is 1, requests are not accepted and the requester must hold them.
- `stall` = `busy` OR (free FIFO slots < 2). The queue can therefore always absorb two pushes in a single cycle.

Same-cycle requests:
- If `br_req` and `jmp_req` are both accepted in one cycle, both entries are pushed in that cycle.
- The `br` entry is pushed first (older in program order), then the `jmp` entry.

Drain:
- When in IDLE and the FIFO is non-empty, pop the head and drive `btb_we`=1, `btb_idx`=`pc[IDX_W+1:2]`, `btb_pc`=`pc`, `btb_target`=`target`, `btb_vld`=1.
- Exactly one write is issued per cycle.
- Pop and push in the same cycle are legal.
- FIFO pointers are `log2(FIFO_DEPTH)+1` bits and wrap modulo 2×depth. Full and empty are decided by comparing the MSB and the remaining pointer bits.

FSM states:
- IDLE: draining the FIFO.
- FLUSH: walking the table with counter `cnt` (`IDX_W` bits).

Transitions:
- IDLE→FLUSH on `flush_req`. On that edge, the FIFO is cleared, `cnt` is set to 0, and `busy` is set to 1.
- In FLUSH, each cycle drives `btb_we`=1, `btb_idx`=`cnt`, `btb_pc`=0, `btb_target`=0, `btb_vld`=0, then increments `cnt`.
- FLUSH→IDLE after the write with `cnt`=`BTB_SIZE`-1.

Boundary cases:
- `flush_req` in the same cycle as accepted requests: the flush wins. Those requests are dropped, not queued.
- `flush_req` while in FLUSH is ignored; the walk is not restarted.
- `reset` asserted mid-flush or mid-drain: state returns to IDLE, the FIFO is emptied, and no further writes occur.
- Pending FIFO entries at flush start are discarded, never written.

## Timing
- All outputs are registered.
- Reset values: `stall`=0, `busy`=0, `btb_we`=0, `btb_idx`=0, `btb_pc`=0, `btb_target`=0, `btb_vld`=0.
- Request accepted at edge N with an empty FIFO gives `btb_we`=1 for that entry during cycle N+1 (one-cycle latency).
- Two requests accepted at edge N: `br` is written in N+1, `jmp` in N+2.
- `flush_req` sampled at edge N:
  - `busy`=1 and `stall`=1 from N+1.
  - Writes with idx 0..`BTB_SIZE`-1 during cycles N+1..N+`BTB_SIZE`.
  - `busy`=0 from N+`BTB_SIZE`+1.
  - The flush takes exactly `BTB_SIZE` cycles.
- `btb_we` is 0 in every cycle with no pop and no walk step.
- `stall` reflects the queue occupancy after the current edge. Its combinational path to `*_req` is not allowed.

## Configuration
- `BTB_UPD_COALESCE_EN` defined:
  - An accepted request whose PC equals the PC of a valid, not-yet-popped FIFO entry overwrites that entry's target in place and does not push.
  - `br` and `jmp` with equal PC in the same cycle produce one entry, carrying the `br` target.
  - A match against the entry being popped in the same cycle pushes normally.
- Not defined: every accepted request pushes a new entry. Duplicates are written to the BTB in order, and the last write wins.

## Test plan
- Reset, then `br_req` with `br_pc`=0x0000_0040, `br_target`=0x0000_0100 → next cycle `btb_we`=1, `btb_idx`=0, `btb_pc`=0x40, `btb_target`=0x100, `btb_vld`=1; the following cycle `btb_we`=0.
- Same-cycle `br` (pc 0x44, target 0x200) and `jmp` (pc 0x88, target 0x300) → idx 1 written first, then idx 2 on the next cycle.
- Four back-to-back dual requests with the drain active → `stall` rises when free slots < 2; no request is lost; writes appear in program order; pointer wrap is exercised.
- `flush_req` with 3 queued entries → 16 writes with idx 0..15 and `btb_vld`=0; `busy` high for exactly 16 cycles; the queued entries are never written; `flush_req` held high during the walk does not restart it.
- `reset` at flush step 5 → outputs at reset values the next cycle; an idle bus follows; a new request is serviced normally.
- With `BTB_UPD_COALESCE_EN`: two requests for pc 0x40 (targets 0x100 then 0x180) while the drain is blocked → one write with target 0x180. Without the macro: two writes, 0x100 then 0x180.
